// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier for the MULTU path
module shift_add_multiplier #(
  parameter int         WIDTH = 32,
  parameter logic [5:0] MULTU = 6'b011001,
  parameter logic [5:0] OUT   = 6'b111111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum;
  logic               start;
  logic               last_iter;

  // A new operation is accepted from IDLE or straight out of DONE
  always_comb begin
    start     = 1'b0;
    last_iter = 1'b0;
    if ((state == IDLE || state == DONE) && Signal == MULTU) begin
      start = 1'b1;
    end
    if (state == RUN && count == CW'(WIDTH - 1)) begin
      last_iter = 1'b1;
    end
  end

  // Upper half plus the conditional multiplicand; the extra bit carries into the top of the shift
  always_comb begin
    sum = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (product[0]) begin
      sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; Signal is only looked at outside RUN, so an operation cannot be aborted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Signal == MULTU) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (Signal == MULTU) begin
          state_nxt = RUN;
        end else if (Signal == OUT) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on start, one add-and-shift per RUN cycle, hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      product <= '0;
      mcand   <= '0;
      count   <= '0;
    end else if (start) begin
      mcand   <= dataA;
      product <= {{WIDTH{1'b0}}, dataB};
      count   <= '0;
    end else if (state == RUN) begin
      product <= {sum, product[WIDTH-1:1]};
      count   <= count + 1'b1;
    end
  end

  assign dataOut = product;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] OUT   = 6'b111111;
  localparam logic [5:0] NOP   = 6'b000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = NOP;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = multiplying, 2 = result held
  int          m_mode  = 0;
  int          m_left  = 0;
  logic [63:0] m_res   = '0;
  logic [63:0] m_out   = '0;
  logic        m_known = 1'b1;

  shift_add_multiplier dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model advances with the clock: product is plain A*B, ready 32 cycles after the start
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode  = 0;
      m_left  = 0;
      m_out   = '0;
      m_known = 1'b1;
    end else begin
      case (m_mode)
        1: begin
          m_left  = m_left - 1;
          m_known = 1'b0;
          if (m_left == 0) begin
            m_mode  = 2;
            m_out   = m_res;
            m_known = 1'b1;
          end
        end
        default: begin
          if (Signal == MULTU) begin
            m_res   = 64'(dataA) * 64'(dataB);
            m_out   = {32'b0, dataB};
            m_known = 1'b1;
            m_left  = 32;
            m_mode  = 1;
          end else if (m_mode == 2 && Signal == OUT) begin
            m_mode = 0;
          end
        end
      endcase
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    chk("busy", {63'b0, busy}, {63'b0, m_mode == 1});
    chk("done", {63'b0, done}, {63'b0, m_mode == 2});
    if (m_known) begin
      chk("dataOut", dataOut, m_out);
    end
  end

  // Issue MULTU for one cycle; returns at the first falling edge after the start edge
  task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = MULTU;
    @(negedge clk);
    Signal = NOP;
    dataA  = $urandom;
    dataB  = $urandom;
    chk("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  // Count busy cycles (already counts those already elapsed), then check the held result
  task automatic wait_done(input string name, input int already, input logic [63:0] exp);
    int n;
    n = already;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'd32);
    chk({name, "_done"}, {63'b0, done}, 64'd1);
    chk({name, "_result"}, dataOut, exp);
    chk({name, "_model"}, m_res, exp);
  endtask

  task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    start_mult(a, b);
    wait_done(name, 0, exp);
  endtask

  initial begin
    #2;
    chk("reset_dataOut", dataOut, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_mult("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_mult("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_mult("zero_b", 32'h12345678, 32'd0, 64'd0);
    run_mult("zero_a", 32'd0, 32'hDEADBEEF, 64'd0);

    // Opcodes during RUN must be ignored
    start_mult(32'd7, 32'd9);
    repeat (9) @(negedge clk);
    dataA  = 32'd2;
    dataB  = 32'd2;
    Signal = MULTU;
    @(negedge clk);
    Signal = OUT;
    @(negedge clk);
    Signal = NOP;
    wait_done("ignore", 11, 64'd63);

    // Acknowledge, then abort a fresh operation with reset mid-run
    @(negedge clk);
    Signal = OUT;
    @(negedge clk);
    Signal = NOP;
    start_mult(32'h10000, 32'h10000);
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_dataOut", dataOut, 64'd0);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {62'b0, busy, done}, 64'd0);
    run_mult("6x7", 32'd6, 32'd7, 64'd42);

    // Restart straight from DONE, then acknowledge
    run_mult("restart", 32'd100, 32'd100, 64'd10000);
    Signal = OUT;
    @(negedge clk);
    Signal = NOP;
    chk("ack_done", {63'b0, done}, 64'd0);
    chk("ack_busy", {63'b0, busy}, 64'd0);
    chk("ack_dataOut", dataOut, 64'd10000);
    repeat (3) @(negedge clk);
    chk("idle_hold", dataOut, 64'd10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential unsigned 32x32 multiplier for the ALU's MULTU path, the multiply counterpart of the shift-subtract divider. It is driven by the same 6-bit Signal opcode bus and returns a 64-bit {HI,LO} product. It uses one add-and-shift iteration per clock and is read out with the OUT opcode.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits
MULTU, 6'b011001, opcode that starts a multiply
OUT, 6'b111111, opcode that acknowledges or reads the result

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
dataA  input  WIDTH  multiplicand, sampled at start
dataB  input  WIDTH  multiplier, sampled at start
Signal  input  6  ALU operation code
dataOut  output  2*WIDTH  product register; {HI,LO} = {[63:32],[31:0]}
busy  output  1  high while iterating
done  output  1  high while a valid result is held

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; product register=0; multiplicand register=0; counter=0.
  - dataOut=0, busy=0, done=0.
  - Applies immediately, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, DONE. All transitions occur on the rising clk edge.
- IDLE:
  - Signal==MULTU at an edge:
    - latch mcand<=dataA;
    - product<={WIDTH'b0, dataB};
    - count<=0;
    - go to RUN.
  - Any other opcode: hold.
- RUN, each edge:
  - sum[WIDTH:0] = {1'b0, product[63:32]} + (product[0] ? {1'b0, mcand} : 0); the 33-bit sum keeps the carry.
  - product <= {sum, product[31:1]}, i.e. a logical right shift with the carry entering bit 63.
  - count<=count+1.
  - The edge where count==WIDTH-1 performs the last iteration and moves to DONE.
- Latency:
  - Start accepted at edge k; the final product is in dataOut after edge k+WIDTH (32).
  - done=1 from that edge onward.
- busy=1 exactly in RUN; done=1 exactly in DONE. Both are registered and decoded from state, so there is no combinational path from Signal.
- Signal during RUN is ignored, including MULTU and OUT. An operation cannot be aborted except by reset.
- DONE:
  - product is held.
  - Signal==OUT at an edge: go to IDLE. dataOut keeps the product until the next start, so software may read after acknowledging.
  - Signal==MULTU at an edge: restart directly (same actions as from IDLE). No idle cycle is required.
  - Any other opcode: hold.
- dataOut is a direct copy of the product register; intermediate values are visible during RUN. Consumers must qualify with done.
- Operands are unsigned. Results never overflow 64 bits (max 0xFFFFFFFE00000001).
- dataA/dataB may change freely after the start edge.
- Reset deasserting asynchronously while Signal==MULTU: the start is taken on the first edge after reset is high.

Test Plan:
- Reset, then MULTU with dataA=3, dataB=5 for one cycle:
  - busy=1 for 32 cycles;
  - then done=1 and dataOut=64'h0000_0000_0000_000F.
- dataA=32'hFFFFFFFF, dataB=32'hFFFFFFFF -> dataOut=64'hFFFFFFFE_00000001 after 32 cycles (exercises the carry into bit 63).
- dataA=32'h12345678, dataB=0; then dataA=0, dataB=32'hDEADBEEF -> dataOut=0 in both cases, with done after exactly 32 cycles.
- Start 7*9; at cycle 10 of RUN, drive MULTU with 2*2, then OUT:
  - both are ignored;
  - done after 32 cycles with dataOut=63 (0x3F).
- Start 32'h10000*32'h10000; pull reset low at cycle 16:
  - dataOut=0, busy=0, done=0 immediately (before the next edge);
  - after release, the FSM is in IDLE and the next MULTU 6*7 yields 42.
- From DONE holding 42:
  - MULTU 100*100 restarts at once (busy next cycle), giving 10000 after 32 cycles;
  - OUT then returns to IDLE (done=0) with dataOut still 10000.
